// File: rtl/regbank_wr_arbiter.sv
// Write-port arbiter for reg_bank: single-cycle WB path vs. buffered LU return path.
// Also produces the ID-stage RAW stall for accepted-but-uncommitted writes.
module regbank_wr_arbiter #(
    parameter int WORD_WIDTH = 32,
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_WAIT   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wb_valid_i,
    output logic                          wb_ready_o,
    input  logic [4:0]                    wb_addr_i,
    input  logic [WORD_WIDTH-1:0]         wb_data_i,
    input  logic                          lu_valid_i,
    output logic                          lu_ready_o,
    input  logic [4:0]                    lu_addr_i,
    input  logic [WORD_WIDTH-1:0]         lu_data_i,
    output logic                          rf_wen_o,
    output logic [4:0]                    rf_waddr_o,
    output logic [WORD_WIDTH-1:0]         rf_wdata_o,
    input  logic [4:0]                    hz_raddr1_i,
    input  logic [4:0]                    hz_raddr2_i,
    output logic                          hz_stall_o,
    output logic [$clog2(FIFO_DEPTH):0]   lu_count_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_WB,
        GNT_LU
    } gnt_e;

    logic [4:0]            fifo_addr [FIFO_DEPTH];
    logic [WORD_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_vld;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [CW-1:0]         count;
    logic [WW-1:0]         wait_cnt;
    logic                  lu_force;

    logic                  lu_empty;
    logic                  lu_full;
    logic                  lu_forced;
    logic                  enq;
    logic                  deq;
    gnt_e                  gnt;
    logic [4:0]            win_addr;
    logic [WORD_WIDTH-1:0] win_data;
    logic                  hit1;
    logic                  hit2;

    assign lu_empty   = (count == '0);
    assign lu_full    = (count == CW'(FIFO_DEPTH));
    assign lu_forced  = lu_force && !lu_empty;
    assign wb_ready_o = !lu_forced;
    assign lu_ready_o = !lu_full;
    assign enq        = lu_valid_i && !lu_full;
    assign deq        = (gnt == GNT_LU);
    assign lu_count_o = count;

    always_comb begin
        gnt = GNT_NONE;
        if (lu_forced)
            gnt = GNT_LU;
        else if (wb_valid_i)
            gnt = GNT_WB;
        else if (!lu_empty)
            gnt = GNT_LU;
    end

    always_comb begin
        win_addr = '0;
        win_data = '0;
        unique case (gnt)
            GNT_WB: begin
                win_addr = wb_addr_i;
                win_data = wb_data_i;
            end
            GNT_LU: begin
                win_addr = fifo_addr[rd_ptr];
                win_data = fifo_data[rd_ptr];
            end
            default: ;
        endcase
    end

    // Payload storage needs no reset; validity is tracked per slot.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_addr[wr_ptr] <= lu_addr_i;
            fifo_data[wr_ptr] <= lu_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_vld <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (deq) begin
                fifo_vld[rd_ptr] <= 1'b0;
                rd_ptr           <= rd_ptr + PW'(1);
            end
            if (enq) begin
                fifo_vld[wr_ptr] <= 1'b1;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            unique case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Force is raised on the edge where the denied-cycle count reaches MAX_WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            lu_force <= 1'b0;
        end else begin
            if (lu_empty || deq)
                wait_cnt <= '0;
            else if (wait_cnt != WW'(MAX_WAIT))
                wait_cnt <= wait_cnt + WW'(1);
            if (deq)
                lu_force <= 1'b0;
            else if (!lu_empty && wait_cnt == WW'(MAX_WAIT - 1))
                lu_force <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wen_o   <= 1'b0;
            rf_waddr_o <= '0;
            rf_wdata_o <= '0;
        end else if (gnt != GNT_NONE) begin
            rf_wen_o   <= (win_addr != 5'd0);
            rf_waddr_o <= win_addr;
            rf_wdata_o <= win_data;
        end else begin
            rf_wen_o   <= 1'b0;
        end
    end

    always_comb begin
        hit1 = rf_wen_o && (rf_waddr_o == hz_raddr1_i);
        hit2 = rf_wen_o && (rf_waddr_o == hz_raddr2_i);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (fifo_vld[i] && fifo_addr[i] == hz_raddr1_i)
                hit1 = 1'b1;
            if (fifo_vld[i] && fifo_addr[i] == hz_raddr2_i)
                hit2 = 1'b1;
        end
    end

    assign hz_stall_o = (hit1 && hz_raddr1_i != 5'd0)
                     || (hit2 && hz_raddr2_i != 5'd0);

endmodule

// File: tb/tb_regbank_wr_arbiter.sv
// Scoreboard bench for regbank_wr_arbiter: queue-based reference model,
// directed scenarios plus randomized WB/LU traffic.
module tb_regbank_wr_arbiter;

    localparam int W  = 32;
    localparam int D  = 2;
    localparam int MW = 4;
    localparam int CW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          wb_valid_i;
    logic          wb_ready_o;
    logic [4:0]    wb_addr_i;
    logic [W-1:0]  wb_data_i;
    logic          lu_valid_i;
    logic          lu_ready_o;
    logic [4:0]    lu_addr_i;
    logic [W-1:0]  lu_data_i;
    logic          rf_wen_o;
    logic [4:0]    rf_waddr_o;
    logic [W-1:0]  rf_wdata_o;
    logic [4:0]    hz_raddr1_i;
    logic [4:0]    hz_raddr2_i;
    logic          hz_stall_o;
    logic [CW-1:0] lu_count_o;

    regbank_wr_arbiter #(.WORD_WIDTH(W), .FIFO_DEPTH(D), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst),
        .wb_valid_i(wb_valid_i), .wb_ready_o(wb_ready_o),
        .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
        .lu_valid_i(lu_valid_i), .lu_ready_o(lu_ready_o),
        .lu_addr_i(lu_addr_i), .lu_data_i(lu_data_i),
        .rf_wen_o(rf_wen_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .hz_raddr1_i(hz_raddr1_i), .hz_raddr2_i(hz_raddr2_i),
        .hz_stall_o(hz_stall_o), .lu_count_o(lu_count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]   a;
        logic [W-1:0] d;
    } ent_t;

    typedef struct {
        logic [4:0]   a;
        logic [W-1:0] d;
        int           c;
    } exp_t;

    ent_t lu_q[$];
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   force_m;
    int   waited;
    bit   cur_wen;
    logic [4:0] cur_addr;
    int   nstep = 0;
    int   ready_low = 0;
    int   last_low = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic bit hz(input logic [4:0] r);
        if (r == 5'd0)
            return 1'b0;
        foreach (lu_q[i])
            if (lu_q[i].a == r)
                return 1'b1;
        return cur_wen && cur_addr == r;
    endfunction

    task automatic model_reset();
        lu_q.delete();
        exp_q.delete();
        force_m  = 1'b0;
        waited   = 0;
        cur_wen  = 1'b0;
        cur_addr = 5'd0;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every committed write must match the next scoreboard entry.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (rf_wen_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rf_unexpected: got addr %0d data %h required none", rf_waddr_o, rf_wdata_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("rf_addr", 32'(rf_waddr_o), 32'(e.a));
                    chk("rf_data", rf_wdata_o, e.d);
                    chk("rf_cycle", 32'(cyc), 32'(e.c));
                end
            end else if (exp_q.size() > 0 && exp_q[0].c <= cyc) begin
                checks++;
                errors++;
                $display("FAIL rf_missing: got no write required addr %0d", exp_q[0].a);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic step(input bit wbv, input logic [4:0] wba, input logic [W-1:0] wbd,
                        input bit luv, input logic [4:0] lua, input logic [W-1:0] lud,
                        input logic [4:0] r1, input logic [4:0] r2,
                        output bit wacc, output bit lacc);
        bit ne, e_wbr, e_lur;
        int win;
        ent_t e;
        logic [4:0] a;
        logic [W-1:0] d;
        wb_valid_i  = wbv;
        wb_addr_i   = wba;
        wb_data_i   = wbd;
        lu_valid_i  = luv;
        lu_addr_i   = lua;
        lu_data_i   = lud;
        hz_raddr1_i = r1;
        hz_raddr2_i = r2;
        #1;
        ne    = lu_q.size() > 0;
        e_wbr = !(force_m && ne);
        e_lur = lu_q.size() < D;
        chk("wb_ready", 32'(wb_ready_o), 32'(e_wbr));
        chk("lu_ready", 32'(lu_ready_o), 32'(e_lur));
        chk("hz_stall", 32'(hz_stall_o), 32'(hz(r1) || hz(r2)));
        chk("lu_count", 32'(lu_count_o), 32'(lu_q.size()));
        if (!wb_ready_o) begin
            ready_low++;
            last_low = nstep;
        end
        win = 0;
        a = 5'd0;
        d = '0;
        if (force_m && ne)
            win = 2;
        else if (wbv)
            win = 1;
        else if (ne)
            win = 2;
        if (win == 1) begin
            a = wba;
            d = wbd;
        end
        if (win == 2) begin
            e = lu_q.pop_front();
            a = e.a;
            d = e.d;
            waited  = 0;
            force_m = 1'b0;
        end else if (ne) begin
            waited++;
            if (waited == MW)
                force_m = 1'b1;
        end else begin
            waited = 0;
        end
        if (luv && e_lur)
            lu_q.push_back('{lua, lud});
        if (win != 0) begin
            cur_wen  = (a != 5'd0);
            cur_addr = a;
            if (cur_wen)
                exp_q.push_back('{a, d, cyc + 1});
        end else begin
            cur_wen = 1'b0;
        end
        wacc = wbv && (win == 1);
        lacc = luv && e_lur;
        nstep++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit wa, la;
        for (int i = 0; i < n; i++)
            step(0, 0, 0, 0, 0, 0, 0, 0, wa, la);
    endtask

    initial begin
        bit wa, la, wbp, lup;
        logic [4:0] wad, lad;
        logic [W-1:0] wdd, ldd;
        int idx, guard, base;

        rst = 1'b1;
        wb_valid_i = 0; wb_addr_i = 0; wb_data_i = 0;
        lu_valid_i = 0; lu_addr_i = 0; lu_data_i = 0;
        hz_raddr1_i = 5'd3; hz_raddr2_i = 5'd0;
        model_reset();
        #2;
        chk("rst_wen", 32'(rf_wen_o), 0);
        chk("rst_waddr", 32'(rf_waddr_o), 0);
        chk("rst_wdata", rf_wdata_o, 0);
        chk("rst_count", 32'(lu_count_o), 0);
        chk("rst_wb_ready", 32'(wb_ready_o), 1);
        chk("rst_lu_ready", 32'(lu_ready_o), 1);
        chk("rst_stall", 32'(hz_stall_o), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // WB only
        step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, wa, la);
        chk("wb_wen", 32'(rf_wen_o), 1);
        chk("wb_waddr", 32'(rf_waddr_o), 5);
        chk("wb_wdata", rf_wdata_o, 32'hDEADBEEF);
        step(0, 0, 0, 0, 0, 0, 5, 0, wa, la);
        idle(2);

        // x0 suppression
        step(1, 0, 32'h1111, 1, 0, 32'h2222, 0, 0, wa, la);
        chk("x0_wen_a", 32'(rf_wen_o), 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, wa, la);
        chk("x0_wen_b", 32'(rf_wen_o), 0);
        chk("x0_count", 32'(lu_count_o), 0);
        idle(2);

        // Contention and FIFO full
        step(1, 10, 32'hA0, 1, 7, 32'h70, 0, 0, wa, la);
        step(1, 11, 32'hA1, 1, 9, 32'h90, 0, 0, wa, la);
        chk("full_count", 32'(lu_count_o), 2);
        chk("full_lu_ready", 32'(lu_ready_o), 0);
        hz_raddr2_i = 5'd9;
        #1;
        chk("full_stall_r9", 32'(hz_stall_o), 1);
        la = 0;
        guard = 0;
        while (!la && guard < 30) begin
            step(1, 5'(12 + guard % 4), 32'(guard), 1, 13, 32'hB0, 0, 9, wa, la);
            guard++;
        end
        chk("third_accepted", 32'(la), 1);
        idle(4);

        // Starvation
        step(1, 20, 32'hC0, 1, 12, 32'h12, 0, 0, wa, la);
        ready_low = 0;
        base = nstep;
        for (int i = 0; i < 10; i++)
            step(1, 5'(21 + i), 32'(i), 0, 0, 0, 0, 0, wa, la);
        chk("starve_low_cycles", 32'(ready_low), 1);
        chk("starve_low_at", 32'(last_low - base), 4);
        idle(3);

        // Wrap and order: LU addr 1..8 with random WB gaps
        idx = 1;
        wbp = 0;
        guard = 0;
        while (idx <= 8 && guard < 300) begin
            if (!wbp && $urandom_range(0, 1) == 1) begin
                wbp = 1;
                wad = 5'($urandom_range(16, 31));
                wdd = $urandom;
            end
            step(wbp, wad, wdd, 1, 5'(idx), 32'(idx * 16), 5'(idx), 0, wa, la);
            if (wa) wbp = 0;
            if (la) idx++;
            guard++;
        end
        chk("wrap_done", 32'(idx), 9);
        idle(6);

        // Randomized traffic with hold-while-stalled requesters
        wbp = 0;
        lup = 0;
        for (int i = 0; i < 400; i++) begin
            if (!wbp && $urandom_range(0, 2) != 0) begin
                wbp = 1;
                wad = 5'($urandom_range(0, 7));
                wdd = $urandom;
            end
            if (!lup && $urandom_range(0, 2) == 0) begin
                lup = 1;
                lad = 5'($urandom_range(0, 7));
                ldd = $urandom;
            end
            step(wbp, wad, wdd, lup, lad, ldd,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), wa, la);
            if (wa) wbp = 0;
            if (la) lup = 0;
        end
        idle(6);

        // Reset mid-operation with two buffered entries
        step(1, 3, 32'h33, 1, 13, 32'hD0, 0, 0, wa, la);
        step(1, 4, 32'h44, 1, 14, 32'hE0, 0, 0, wa, la);
        chk("pre_rst_count", 32'(lu_count_o), 2);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_count", 32'(lu_count_o), 0);
        chk("mid_rst_wen", 32'(rf_wen_o), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        wb_valid_i = 0;
        lu_valid_i = 0;
        hz_raddr1_i = 5'd13;
        hz_raddr2_i = 5'd14;
        #1;
        chk("post_rst_lu_ready", 32'(lu_ready_o), 1);
        chk("post_rst_wb_ready", 32'(wb_ready_o), 1);
        chk("post_rst_stall", 32'(hz_stall_o), 0);
        @(negedge clk);
        step(1, 6, 32'h66, 0, 0, 0, 0, 0, wa, la);
        idle(4);

        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regbank_wr_arbiter.md
Name: regbank_wr_arbiter

Overview:
Arbitrates the register bank's single write port between two requesters. Requester WB is the single-cycle writeback path carrying ALU and link results. Requester LU is the long-latency load/mul-div return path, which is buffered in a small FIFO. The block sits between the WB stage and reg_bank, and also provides the ID stage with a read-after-write stall for writes that have been accepted but not yet committed.

Parameters:
WORD_WIDTH, 32, register data width
FIFO_DEPTH, 2, LU buffer entries (power of 2, >=2)
MAX_WAIT, 4, consecutive cycles a non-empty LU head may be denied before it is forced

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
wb_valid_i  in  1  WB write request
wb_ready_o  out  1  WB request accepted this cycle
wb_addr_i  in  5  WB destination register
wb_data_i  in  WORD_WIDTH  WB write data
lu_valid_i  in  1  LU write request
lu_ready_o  out  1  LU request accepted into FIFO
lu_addr_i  in  5  LU destination register
lu_data_i  in  WORD_WIDTH  LU write data
rf_wen_o  out  1  reg_bank write enable (registered)
rf_waddr_o  out  5  reg_bank write address (registered)
rf_wdata_o  out  WORD_WIDTH  reg_bank write data (registered)
hz_raddr1_i  in  5  ID rs1 address
hz_raddr2_i  in  5  ID rs2 address
hz_stall_o  out  1  ID must stall (combinational)
lu_count_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (asynchronous, active-high): FIFO empty, wait counter 0, force flag 0.
  - rf_wen_o=0, rf_waddr_o=0, rf_wdata_o=0, lu_count_o=0.
  - Combinational outputs at reset: wb_ready_o=1, lu_ready_o=1, hz_stall_o=0.
- Reset mid-operation: drops all FIFO contents and any registered write. No partial write is ever issued.
- Handshakes: a transfer occurs when valid&&ready at a rising edge. Requesters hold addr/data stable while valid is high and ready is low.
- lu_ready_o = (count < FIFO_DEPTH). There is no full-with-dequeue bypass; when full, ready stays 0 even if the head drains that cycle.
- Enqueue and dequeue in the same cycle are allowed when not full. Count is unchanged and the pointers wrap modulo FIFO_DEPTH.
- Grant, evaluated each cycle in priority order:
  1. force=1 and FIFO non-empty -> LU head; wb_ready_o=0.
  2. else wb_valid_i -> WB; wb_ready_o=1.
  3. else FIFO non-empty -> LU head.
  4. else no grant.
- wb_ready_o = !(force && FIFO non-empty).
- Output register: on a grant, the next edge loads rf_waddr_o/rf_wdata_o from the winner and sets rf_wen_o = (addr != 0). With no grant, rf_wen_o=0 and addr/data hold.
- x0 writes are accepted, dequeued and consumed without asserting rf_wen_o.
- Latency:
  - WB: handshake at edge N -> rf_wen_o high for cycle N..N+1 (written by reg_bank at edge N+1).
  - LU into empty FIFO, no WB contention: enqueue at edge N, dequeue at edge N+1, rf_wen_o high after edge N+1.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and the head is not dequeued. Clears on any dequeue or when the FIFO is empty.
  - When the counter == MAX_WAIT at an edge, force=1 from that edge. force clears on the next dequeue.
  - With a stuck WB, LU therefore waits at most MAX_WAIT+1 cycles.
- Hazard: hz_stall_o=1 if a nonzero hz_raddr1_i or hz_raddr2_i matches either:
  - (a) the address of any valid FIFO entry, or
  - (b) rf_waddr_o while rf_wen_o=1.
- Address 0 never stalls. In-flight requests not yet accepted are not tracked.
- Same register pending from both sources: commit order equals grant order. No reordering within the LU FIFO.

Test Plan:
- Reset: assert rst mid-cycle while the FIFO holds 2 entries -> lu_count_o=0, rf_wen_o=0 immediately; after release, lu_ready_o=1 and hz_stall_o=0.
- WB only: wb_valid_i=1, addr=5, data=0xDEADBEEF at edge N -> rf_wen_o=1, rf_waddr_o=5, rf_wdata_o=0xDEADBEEF during cycle N+1; hz_stall_o=1 for hz_raddr1_i=5 in that cycle.
- x0 suppression: WB addr=0 and LU addr=0 -> both accepted, rf_wen_o stays 0, hz_raddr1_i=0 never stalls.
- Contention and FIFO full:
  - Stimulus: WB valid every cycle; LU pushes addr 7, then addr 9, then a third request.
  - Required: entries 7 and 9 are buffered; lu_ready_o=0 on the third request; lu_count_o=2; hz_stall_o=1 for raddr2=9.
- Starvation (MAX_WAIT=4): WB valid continuously, one LU entry queued -> after 4 denied cycles, wb_ready_o=0 for exactly one cycle, the LU entry appears on rf_*, then WB resumes.
- Wrap/order: 8 LU writes (addr 1..8) interleaved with random WB gaps -> reg_bank writes occur in order 1..8; the FIFO pointers wrap with no loss or duplication.
